// File: rtl/cpu_pipe_pkg.sv
// Shared ID/EX pipeline types: the decode bundle, bubble construction and pipe FSM states.
// Pure declarations; no timing or flow control of its own.
package cpu_pipe_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_BITS = 5;
  localparam int ALUOP_BITS    = 4;
  localparam int FUNC3_BITS    = 3;
  localparam int FUNC7_BITS    = 7;
  localparam int DATATYPE_BITS = 3;
  localparam int BRANCH_BITS   = 3;
  localparam int RD_SRC_BITS   = 2;
  localparam int CSR_ADDR_BITS = 12;

  localparam logic [BRANCH_BITS-1:0] BRANCH_NONE = '0;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [ALUOP_BITS-1:0]    aluop;
    logic [FUNC3_BITS-1:0]    func3;
    logic [FUNC7_BITS-1:0]    func7;
    logic [XLEN-1:0]          imm;
    logic [DATATYPE_BITS-1:0] datatype;
    logic [REG_ADDR_BITS-1:0] rs1_addr;
    logic [XLEN-1:0]          rs1_data;
    logic [REG_ADDR_BITS-1:0] rs2_addr;
    logic [XLEN-1:0]          rs2_data;
    logic [REG_ADDR_BITS-1:0] rd_addr;
    logic [BRANCH_BITS-1:0]   branch_ctrl;
    logic                     alu_src;
    logic                     pc2reg_src;
    logic                     reg_wr;
    logic [RD_SRC_BITS-1:0]   rd_src;
    logic                     dm2reg;
    logic                     dm_rd;
    logic                     dm_wr;
    logic [CSR_ADDR_BITS-1:0] csr_addr;
    logic                     csr;
    logic                     csr_src;
    logic                     csr_wr;
    logic                     csr_set;
    logic                     csr_clr;
    logic                     csr_mret;
    logic                     csr_wfi;
  } id_ex_t;

  typedef enum logic {RUN = 1'b0, SLEEP = 1'b1} pipe_state_e;

  // Side-effecting controls are always killed; data fields only when zero_data is set.
  function automatic id_ex_t id_ex_bubble(input id_ex_t b, input bit zero_data);
    id_ex_t r;
    r             = zero_data ? id_ex_t'('0) : b;
    r.reg_wr      = 1'b0;
    r.dm_rd       = 1'b0;
    r.dm_wr       = 1'b0;
    r.dm2reg      = 1'b0;
    r.csr         = 1'b0;
    r.csr_wr      = 1'b0;
    r.csr_set     = 1'b0;
    r.csr_clr     = 1'b0;
    r.csr_mret    = 1'b0;
    r.csr_wfi     = 1'b0;
    r.branch_ctrl = BRANCH_NONE;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary signals; master is the ID/control side, slave is the pipeline register.
// No storage; backpressure is carried by ex_stall and id_hold.
interface id_ex_pipe_reg_if #(
  parameter int PERF_CNT_BITS = 16
);
  import cpu_pipe_pkg::*;

  logic                     id_valid;
  id_ex_t                   id_bundle;
  logic                     ex_stall;
  logic                     flush;
  logic                     irq_wake;
  logic                     ex_valid;
  id_ex_t                   ex_bundle;
  logic                     load_use_stall;
  logic                     id_hold;
  logic                     wfi_sleep;
  logic [PERF_CNT_BITS-1:0] bubble_cnt;

  modport master (
    output id_valid, id_bundle, ex_stall, flush, irq_wake,
    input  ex_valid, ex_bundle, load_use_stall, id_hold, wfi_sleep, bubble_cnt
  );

  modport slave (
    input  id_valid, id_bundle, ex_stall, flush, irq_wake,
    output ex_valid, ex_bundle, load_use_stall, id_hold, wfi_sleep, bubble_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the instruction in ID and a load sitting in EX.
// Purely combinational, zero latency; raises hazard so the caller can bubble and hold ID.
module load_use_detect
  import cpu_pipe_pkg::*;
(
  input  logic   id_valid,
  input  id_ex_t id_bundle,
  input  logic   ex_valid,
  input  id_ex_t ex_bundle,
  output logic   hazard
);

  logic hit_rs1;
  logic hit_rs2;
  logic rs2_used;

  // rs2 only matters when it feeds the ALU, the store data, or a branch compare.
  assign rs2_used = !id_bundle.alu_src || id_bundle.dm_wr ||
                    (id_bundle.branch_ctrl != BRANCH_NONE);
  assign hit_rs1  = (ex_bundle.rd_addr == id_bundle.rs1_addr);
  assign hit_rs2  = (ex_bundle.rd_addr == id_bundle.rs2_addr) && rs2_used;

  assign hazard = id_valid && ex_valid && ex_bundle.dm_rd &&
                  (ex_bundle.rd_addr != '0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubbles, flush, and WFI parking; one cycle ID to EX.
// Holds on ex_stall; id_hold tells IF/ID to freeze during stalls, load-use hazards and sleep.
module id_ex_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int PERF_CNT_BITS  = 16,
  parameter bit ZERO_ON_BUBBLE = 1'b1
) (
  input logic             clk,
  input logic             rst,
  id_ex_pipe_reg_if.slave bus
);

  logic                     ex_valid_q;
  id_ex_t                   ex_bundle_q;
  pipe_state_e              state_q;
  logic [PERF_CNT_BITS-1:0] bubble_cnt_q;
  logic                     hazard;
  logic                     capture;
  logic                     sleeping;

  load_use_detect u_load_use_detect (
    .id_valid  (bus.id_valid),
    .id_bundle (bus.id_bundle),
    .ex_valid  (ex_valid_q),
    .ex_bundle (ex_bundle_q),
    .hazard    (hazard)
  );

  assign sleeping = (state_q == SLEEP);
  assign capture  = !bus.flush && !bus.ex_stall && !sleeping && !hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_bundle_q  <= '0;
      state_q      <= RUN;
      bubble_cnt_q <= '0;
    end else begin
      if (bus.flush) begin
        ex_valid_q  <= 1'b0;
        ex_bundle_q <= id_ex_bubble(ex_bundle_q, ZERO_ON_BUBBLE);
      end else if (bus.ex_stall) begin
        ex_valid_q  <= ex_valid_q;
        ex_bundle_q <= ex_bundle_q;
      end else if (sleeping || hazard) begin
        ex_valid_q  <= 1'b0;
        ex_bundle_q <= id_ex_bubble(ex_bundle_q, ZERO_ON_BUBBLE);
        if (!sleeping && (bubble_cnt_q != {PERF_CNT_BITS{1'b1}})) begin
          bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
      end else begin
        ex_valid_q  <= bus.id_valid;
        ex_bundle_q <= bus.id_bundle;
      end

      // The WFI itself still goes to EX; only what follows it is parked.
      if (bus.flush) begin
        state_q <= RUN;
      end else if (sleeping && bus.irq_wake) begin
        state_q <= RUN;
      end else if (capture && bus.id_valid && bus.id_bundle.csr_wfi && !bus.irq_wake) begin
        state_q <= SLEEP;
      end
    end
  end

  assign bus.ex_valid       = ex_valid_q;
  assign bus.ex_bundle      = ex_bundle_q;
  assign bus.load_use_stall = hazard && !rst;
  assign bus.id_hold        = !rst && (bus.ex_stall || hazard || sleeping);
  assign bus.wfi_sleep      = sleeping;
  assign bus.bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vectors, a rule-level reference model and literal spot checks.
module tb_id_ex_pipe_reg;
  import cpu_pipe_pkg::*;

  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic run_chk = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.PERF_CNT_BITS(CW)) bus ();

  id_ex_pipe_reg #(.PERF_CNT_BITS(CW), .ZERO_ON_BUBBLE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state: what EX should hold, whether parked, and how many bubbles were owed.
  logic   m_valid;
  id_ex_t m_bundle;
  logic   m_sleep;
  int     m_total;

  function automatic logic m_hazard();
    id_ex_t e;
    id_ex_t d;
    e = m_bundle;
    d = bus.id_bundle;
    if (!(bus.id_valid && m_valid && e.dm_rd) || e.rd_addr == 0) return 1'b0;
    if (e.rd_addr == d.rs1_addr) return 1'b1;
    return (e.rd_addr == d.rs2_addr) && (!d.alu_src || d.dm_wr || d.branch_ctrl != 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_bundle <= '0;
      m_sleep  <= 1'b0;
      m_total  <= 0;
    end else if (bus.flush) begin
      m_valid  <= 1'b0;
      m_bundle <= '0;
      m_sleep  <= 1'b0;
    end else if (bus.ex_stall) begin
      if (m_sleep && bus.irq_wake) m_sleep <= 1'b0;
    end else if (m_sleep) begin
      m_valid  <= 1'b0;
      m_bundle <= '0;
      if (bus.irq_wake) m_sleep <= 1'b0;
    end else if (m_hazard()) begin
      m_valid  <= 1'b0;
      m_bundle <= '0;
      m_total  <= m_total + 1;
    end else begin
      m_valid  <= bus.id_valid;
      m_bundle <= bus.id_bundle;
      if (bus.id_valid && bus.id_bundle.csr_wfi && !bus.irq_wake) m_sleep <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input id_ex_t act, input id_ex_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
      chk_b("ex_bundle", bus.ex_bundle, m_bundle);
      chk("wfi_sleep", 32'(bus.wfi_sleep), 32'(m_sleep));
      chk("bubble_cnt", 32'(bus.bubble_cnt), (m_total > CNT_MAX) ? CNT_MAX : m_total);
      chk("load_use_stall", 32'(bus.load_use_stall), 32'(!rst && m_hazard()));
      chk("id_hold", 32'(bus.id_hold), 32'(!rst && (bus.ex_stall || m_hazard() || m_sleep)));
    end
  end

  function automatic id_ex_t ins(input logic [31:0] pc, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2);
    id_ex_t b;
    b          = '0;
    b.pc       = pc;
    b.rd_addr  = rd;
    b.rs1_addr = rs1;
    b.rs2_addr = rs2;
    b.rs1_data = pc ^ 32'hA5A5_0000;
    b.rs2_data = pc ^ 32'h0000_5A5A;
    b.imm      = pc + 32'd4;
    b.aluop    = 4'd3;
    return b;
  endfunction

  function automatic id_ex_t lw(input logic [31:0] pc, input logic [4:0] rd);
    id_ex_t b;
    b         = ins(pc, rd, 5'd1, 5'd0);
    b.alu_src = 1'b1;
    b.dm_rd   = 1'b1;
    b.dm2reg  = 1'b1;
    b.reg_wr  = 1'b1;
    return b;
  endfunction

  function automatic id_ex_t wfi(input logic [31:0] pc);
    id_ex_t b;
    b         = ins(pc, 5'd0, 5'd0, 5'd0);
    b.csr     = 1'b1;
    b.csr_wfi = 1'b1;
    return b;
  endfunction

  task automatic present(input logic v, input id_ex_t b);
    bus.id_valid  = v;
    bus.id_bundle = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  id_ex_t b;

  initial begin
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.irq_wake = 1'b0;
    bus.ex_stall = 1'b1;
    present(1'b1, lw(32'h55, 5'd5));
    #12;
    chk("reset ex_valid", 32'(bus.ex_valid), 0);
    chk_b("reset ex_bundle", bus.ex_bundle, '0);
    chk("reset bubble_cnt", 32'(bus.bubble_cnt), 0);
    chk("reset wfi_sleep", 32'(bus.wfi_sleep), 0);
    chk("reset id_hold", 32'(bus.id_hold), 0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.ex_stall = 1'b0;
    present(1'b0, '0);
    run_chk = 1'b1;

    // plain flow
    b = ins(32'h100, 5'd1, 5'd2, 5'd3);
    b.reg_wr = 1'b1;
    present(1'b1, b);
    tick();
    chk("plain ex_valid", 32'(bus.ex_valid), 1);
    chk("plain pc", bus.ex_bundle.pc, 32'h100);
    #1 chk("plain id_hold", 32'(bus.id_hold), 0);

    // load-use on rs1
    present(1'b1, lw(32'h104, 5'd5));
    tick();
    b = ins(32'h108, 5'd7, 5'd5, 5'd6);
    b.reg_wr = 1'b1;
    present(1'b1, b);
    #1;
    chk("lu stall", 32'(bus.load_use_stall), 1);
    chk("lu id_hold", 32'(bus.id_hold), 1);
    tick();
    chk("lu bubble valid", 32'(bus.ex_valid), 0);
    chk("lu bubble reg_wr", 32'(bus.ex_bundle.reg_wr), 0);
    chk("lu bubble_cnt", 32'(bus.bubble_cnt), 1);
    tick();
    chk("lu resume pc", bus.ex_bundle.pc, 32'h108);
    chk("lu resume valid", 32'(bus.ex_valid), 1);

    // load to x0 never stalls
    present(1'b1, lw(32'h10c, 5'd0));
    tick();
    present(1'b1, ins(32'h110, 5'd8, 5'd0, 5'd0));
    #1 chk("x0 no stall", 32'(bus.load_use_stall), 0);
    tick();
    chk("x0 pc", bus.ex_bundle.pc, 32'h110);

    // rs2 qualification: immediate op ignores rs2, store uses it
    present(1'b1, lw(32'h114, 5'd5));
    tick();
    b = ins(32'h118, 5'd9, 5'd1, 5'd5);
    b.alu_src = 1'b1;
    present(1'b1, b);
    #1 chk("addi no stall", 32'(bus.load_use_stall), 0);
    tick();
    chk("addi pc", bus.ex_bundle.pc, 32'h118);
    present(1'b1, lw(32'h11c, 5'd5));
    tick();
    b = ins(32'h120, 5'd0, 5'd2, 5'd5);
    b.alu_src = 1'b1;
    b.dm_wr   = 1'b1;
    present(1'b1, b);
    #1 chk("sw stall", 32'(bus.load_use_stall), 1);
    tick();
    tick();
    chk("sw pc", bus.ex_bundle.pc, 32'h120);
    present(1'b1, lw(32'h124, 5'd5));
    tick();
    b = ins(32'h128, 5'd0, 5'd3, 5'd5);
    b.alu_src     = 1'b1;
    b.branch_ctrl = 3'd1;
    present(1'b1, b);
    #1 chk("branch stall", 32'(bus.load_use_stall), 1);
    tick();
    tick();

    // back-pressure then flush under stall
    b = ins(32'h200, 5'd0, 5'd1, 5'd2);
    b.dm_wr = 1'b1;
    present(1'b1, b);
    tick();
    bus.ex_stall = 1'b1;
    present(1'b1, ins(32'h204, 5'd11, 5'd1, 5'd2));
    repeat (3) tick();
    chk("stall pc held", bus.ex_bundle.pc, 32'h200);
    chk("stall valid held", 32'(bus.ex_valid), 1);
    bus.flush = 1'b1;
    tick();
    chk("flush valid", 32'(bus.ex_valid), 0);
    chk("flush dm_wr", 32'(bus.ex_bundle.dm_wr), 0);
    bus.flush    = 1'b0;
    bus.ex_stall = 1'b0;
    tick();

    // WFI park and irq wake
    present(1'b1, wfi(32'h300));
    tick();
    chk("wfi sleep", 32'(bus.wfi_sleep), 1);
    chk("wfi in ex", bus.ex_bundle.pc, 32'h300);
    present(1'b1, ins(32'h304, 5'd10, 5'd1, 5'd2));
    #1 chk("wfi id_hold", 32'(bus.id_hold), 1);
    tick();
    chk("sleep ex_valid", 32'(bus.ex_valid), 0);
    tick();
    bus.irq_wake = 1'b1;
    tick();
    chk("wake wfi_sleep", 32'(bus.wfi_sleep), 0);
    bus.irq_wake = 1'b0;
    tick();
    chk("wake resume pc", bus.ex_bundle.pc, 32'h304);

    // WFI with wake already pending does not park; flush leaves SLEEP
    present(1'b1, wfi(32'h308));
    bus.irq_wake = 1'b1;
    tick();
    chk("wfi+irq no sleep", 32'(bus.wfi_sleep), 0);
    bus.irq_wake = 1'b0;
    present(1'b1, wfi(32'h30c));
    tick();
    present(1'b1, ins(32'h310, 5'd12, 5'd1, 5'd2));
    tick();
    bus.flush = 1'b1;
    tick();
    chk("flush wakes", 32'(bus.wfi_sleep), 0);
    bus.flush = 1'b0;
    tick();
    chk("post flush pc", bus.ex_bundle.pc, 32'h310);

    // counter saturation
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      present(1'b1, lw(32'h1000 + 32'(i * 8), 5'd5));
      tick();
      present(1'b1, ins(32'h1004 + 32'(i * 8), 5'd6, 5'd5, 5'd0));
      tick();
    end
    chk("saturated", 32'(bus.bubble_cnt), 32'hFF);

    // async reset while parked and stalled
    present(1'b1, wfi(32'h400));
    tick();
    present(1'b1, ins(32'h404, 5'd13, 5'd1, 5'd2));
    bus.ex_stall = 1'b1;
    tick();
    chk("pre-reset sleep", 32'(bus.wfi_sleep), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst wfi_sleep", 32'(bus.wfi_sleep), 0);
    chk("arst ex_valid", 32'(bus.ex_valid), 0);
    chk("arst bubble_cnt", 32'(bus.bubble_cnt), 0);
    chk("arst id_hold", 32'(bus.id_hold), 0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.ex_stall = 1'b0;
    tick();
    chk("post reset pc", bus.ex_bundle.pc, 32'h404);
    tick();
    run_chk = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
